// File: rtl/layer_sched.sv
// layer_sched: top-level sequencer for the LeNet inference pipeline.
// Runs NUM_LAYERS engines in index order: a one-cycle enable pulse, wait
// for the engine's done, then hold its DRAM grant for DRAIN_CYC trailing
// cycles before kicking the next engine. Counts busy cycles and raises a
// sticky error if one layer stays in RUN longer than TIMEOUT_CYC cycles.
// Ports:
//   clk, srst (sync active-high), start      control
//   busy, done, err, layer_idx, cycle_cnt    status (registered)
//   eng_en / eng_done                        per-engine handshake
//   eng_addr_in/out, eng_data_out, eng_en_rd/wr  packed engine DRAM requests
//   eng_valid                                dram_valid routed to granted engine
//   dram_*                                   muxed DRAM port (combinational from grant)
module layer_sched #(
  parameter int unsigned NUM_LAYERS  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 18,
  parameter int unsigned DRAIN_CYC   = 2,
  parameter int unsigned TIMEOUT_CYC = 262143
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [2:0]                       layer_idx,
  output logic [31:0]                      cycle_cnt,
  output logic [NUM_LAYERS-1:0]            eng_en,
  input  logic [NUM_LAYERS-1:0]            eng_done,
  input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] eng_addr_in,
  input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] eng_addr_out,
  input  logic [NUM_LAYERS*DATA_WIDTH-1:0] eng_data_out,
  input  logic [NUM_LAYERS-1:0]            eng_en_rd,
  input  logic [NUM_LAYERS-1:0]            eng_en_wr,
  output logic [NUM_LAYERS-1:0]            eng_valid,
  input  logic                             dram_valid,
  output logic [ADDR_WIDTH-1:0]            dram_addr_in,
  output logic [ADDR_WIDTH-1:0]            dram_addr_out,
  output logic [DATA_WIDTH-1:0]            dram_data_out,
  output logic                             dram_en_rd,
  output logic                             dram_en_wr
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned IDX_W = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KICK   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [IDX_W-1:0]      layer_idx_q, layer_idx_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [DRN_W-1:0]      drn_q, drn_d;
  logic [31:0]           cycle_cnt_q, cycle_cnt_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NUM_LAYERS-1:0] eng_en_q, eng_en_d;
  logic                  grant;
  logic                  done_sel;

  // Grant is held from the kick through the drain window of the active layer.
  assign grant = (state_q == S_KICK) || (state_q == S_RUN) || (state_q == S_DRAIN);

  // DRAM port mux and done select for the engine at layer_idx.
  always_comb begin
    dram_addr_in  = '0;
    dram_addr_out = '0;
    dram_data_out = '0;
    dram_en_rd    = 1'b0;
    dram_en_wr    = 1'b0;
    eng_valid     = '0;
    done_sel      = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (layer_idx_q == IDX_W'(i)) begin
        done_sel = eng_done[i];
        if (grant) begin
          dram_addr_in  = eng_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
          dram_addr_out = eng_addr_out[i*ADDR_WIDTH +: ADDR_WIDTH];
          dram_data_out = eng_data_out[i*DATA_WIDTH +: DATA_WIDTH];
          dram_en_rd    = eng_en_rd[i];
          dram_en_wr    = eng_en_wr[i];
          eng_valid[i]  = dram_valid;
        end
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    wd_d        = wd_q;
    drn_d       = drn_q;
    err_d       = err_q;
    cycle_cnt_d = cycle_cnt_q;
    if ((state_q != S_IDLE) && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_KICK;
          layer_idx_d = '0;
          cycle_cnt_d = '0;
          err_d       = 1'b0;
        end
      end
      S_KICK: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      S_RUN: begin
        // A done arriving on the timeout cycle still counts as success.
        if (done_sel) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYC)) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DRAIN: begin
        if (drn_q == DRN_W'(DRAIN_CYC - 1)) begin
          if (layer_idx_q == IDX_W'(NUM_LAYERS - 1)) begin
            state_d = S_FINISH;
          end else begin
            state_d     = S_KICK;
            layer_idx_d = layer_idx_q + IDX_W'(1);
          end
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR: begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_FINISH);
    eng_en_d = '0;
    if (state_d == S_KICK) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        if (layer_idx_d == IDX_W'(i)) eng_en_d[i] = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      layer_idx_q <= '0;
      wd_q        <= '0;
      drn_q       <= '0;
      cycle_cnt_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      eng_en_q    <= '0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      wd_q        <= wd_d;
      drn_q       <= drn_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      eng_en_q    <= eng_en_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign layer_idx = layer_idx_q;
  assign cycle_cnt = cycle_cnt_q;
  assign eng_en    = eng_en_q;

endmodule

// File: tb/tb_layer_sched.sv
// tb_layer_sched: randomized directed-sequence bench for layer_sched.
// Expected behaviour comes from a per-run schedule computed with plain
// arithmetic at start accept (kick cycle, grant window and end cycle of
// every layer); stub engines answer the DUT's enable pulses.
module tb_layer_sched;

  localparam int NL = 5;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int DR = 2;
  localparam int TO = 50;

  logic            clk = 1'b0;
  logic            srst = 1'b1;
  logic            start = 1'b0;
  logic            busy, done, err;
  logic [2:0]      layer_idx;
  logic [31:0]     cycle_cnt;
  logic [NL-1:0]   eng_en;
  logic [NL-1:0]   eng_done = '0;
  logic [NL*AW-1:0] eng_addr_in = '0;
  logic [NL*AW-1:0] eng_addr_out = '0;
  logic [NL*DW-1:0] eng_data_out = '0;
  logic [NL-1:0]   eng_en_rd = '0;
  logic [NL-1:0]   eng_en_wr = '0;
  logic [NL-1:0]   eng_valid;
  logic            dram_valid = 1'b0;
  logic [AW-1:0]   dram_addr_in, dram_addr_out;
  logic [DW-1:0]   dram_data_out;
  logic            dram_en_rd, dram_en_wr;

  layer_sched #(
    .NUM_LAYERS(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .DRAIN_CYC(DR), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .srst(srst), .start(start),
    .busy(busy), .done(done), .err(err),
    .layer_idx(layer_idx), .cycle_cnt(cycle_cnt),
    .eng_en(eng_en), .eng_done(eng_done),
    .eng_addr_in(eng_addr_in), .eng_addr_out(eng_addr_out),
    .eng_data_out(eng_data_out), .eng_en_rd(eng_en_rd), .eng_en_wr(eng_en_wr),
    .eng_valid(eng_valid), .dram_valid(dram_valid),
    .dram_addr_in(dram_addr_in), .dram_addr_out(dram_addr_out),
    .dram_data_out(dram_data_out), .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Run schedule: len[k]==0 means engine k never signals done.
  int len[NL];
  int ek[NL];
  int gend[NL];
  int done_at[NL];
  int t0 = 0, end_c = 0, nl = 0;
  bit have_run = 0, complete = 0, timed = 0;
  int bef_idx = 0, bef_cnt = 0, aft_idx = 0, aft_cnt = 0;
  bit bef_err = 0, aft_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic accept(input int c);
    int e;
    bit stop;
    if (have_run) begin
      bef_idx = aft_idx; bef_cnt = aft_cnt; bef_err = aft_err;
    end
    t0 = c; e = c + 1; complete = 1; timed = 0; nl = NL; stop = 0;
    for (int k = 0; k < NL; k++) begin
      done_at[k] = -1;
      if (!stop) begin
        ek[k] = e;
        if (len[k] == 0) begin
          gend[k] = e + TO + 1;
          end_c = e + TO + 2;
          nl = k + 1; complete = 0; timed = 1; stop = 1;
        end else begin
          gend[k] = e + len[k] + DR;
          e = gend[k] + 1;
        end
      end
    end
    if (complete) end_c = e;
    aft_idx = nl - 1; aft_cnt = end_c - t0; aft_err = timed;
    have_run = 1;
  endtask

  // One clock cycle: drive inputs, check every output against the schedule.
  task automatic step(input bit st, input bit rs);
    int c, g, ei, e_idx, e_cnt;
    bit run_now, e_busy, e_done, e_err;
    logic [NL-1:0] e_en, e_val;
    logic e_rd, e_wr;
    logic [AW-1:0] e_ai, e_ao;
    logic [DW-1:0] e_do;
    @(posedge clk); #1;
    c = cyc;
    run_now = have_run && c > t0 && c <= end_c;
    e_busy = run_now; e_done = run_now && complete && c == end_c;
    e_err = 0; e_en = '0; g = -1; e_idx = bef_idx; e_cnt = bef_cnt;
    if (run_now) begin
      ei = 0;
      for (int k = 0; k < nl; k++) if (ek[k] <= c) ei = k;
      e_idx = ei; e_cnt = c - t0 - 1;
      if (c == ek[ei]) e_en[ei] = 1'b1;
      if (c <= gend[ei]) g = ei;
    end else if (have_run && c > end_c) begin
      e_idx = aft_idx; e_cnt = aft_cnt; e_err = aft_err;
    end else begin
      e_err = bef_err;
    end
    // Stub engines: done len cycles after the observed enable, plus junk dones
    // wherever the scheduler must ignore them.
    for (int k = 0; k < NL; k++) begin
      if (eng_en[k] === 1'b1 && len[k] > 0) done_at[k] = c + len[k];
    end
    for (int k = 0; k < NL; k++) begin
      logic d;
      d = (done_at[k] == c);
      if (k != g || c == ek[k] || (len[k] > 0 && c > ek[k] + len[k]))
        d = d | ($urandom_range(3) == 0);
      eng_done[k] = d;
      eng_en_rd[k] = 1'($urandom_range(1));
      eng_en_wr[k] = 1'($urandom_range(1));
      eng_addr_in[k*AW +: AW] = AW'($urandom);
      eng_addr_out[k*AW +: AW] = AW'($urandom);
      eng_data_out[k*DW +: DW] = DW'($urandom);
    end
    dram_valid = 1'($urandom_range(1));
    start = st;
    srst = rs;
    #1;
    e_val = '0; e_rd = 0; e_wr = 0; e_ai = '0; e_ao = '0; e_do = '0;
    if (g >= 0) begin
      e_val[g] = dram_valid;
      e_rd = eng_en_rd[g]; e_wr = eng_en_wr[g];
      e_ai = eng_addr_in[g*AW +: AW];
      e_ao = eng_addr_out[g*AW +: AW];
      e_do = eng_data_out[g*DW +: DW];
    end
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("err", 64'(err), 64'(e_err));
    chk("layer_idx", 64'(layer_idx), 64'(e_idx));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(e_cnt));
    chk("eng_en", 64'(eng_en), 64'(e_en));
    chk("eng_valid", 64'(eng_valid), 64'(e_val));
    chk("dram_en_rd", 64'(dram_en_rd), 64'(e_rd));
    chk("dram_en_wr", 64'(dram_en_wr), 64'(e_wr));
    chk("dram_addr_in", 64'(dram_addr_in), 64'(e_ai));
    chk("dram_addr_out", 64'(dram_addr_out), 64'(e_ao));
    chk("dram_data_out", 64'(dram_data_out), 64'(e_do));
    if (rs) begin
      bef_idx = 0; bef_cnt = 0; bef_err = 0;
      aft_idx = 0; aft_cnt = 0; aft_err = 0;
      if (have_run && c > t0 && c <= end_c) begin
        end_c = c; complete = 0;
      end
    end else if (st && (!have_run || c > end_c)) begin
      accept(c);
    end
    cyc++;
  endtask

  task automatic set_lens(input int a, input int b, input int c, input int d, input int e);
    len[0] = a; len[1] = b; len[2] = c; len[3] = d; len[4] = e;
  endtask

  task automatic rand_lens();
    for (int k = 0; k < NL; k++) len[k] = $urandom_range(20, 1);
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin
      ek[k] = -100; gend[k] = -100; done_at[k] = -1; len[k] = 10;
    end
    repeat (3) @(posedge clk);
    // Reset state, then idle cycles
    repeat (4) step(0, 0);

    // Fixed 10-cycle engines
    set_lens(10, 10, 10, 10, 10);
    step(1, 0);
    repeat (75) step(0, 0);

    // Random layer lengths, including 1-cycle engines
    rand_lens();
    step(1, 0);
    repeat (120) step(0, 0);
    set_lens(1, 1, 1, 1, 1);
    step(1, 0);
    repeat (25) step(0, 0);

    // Engine 2 never finishes: watchdog error, then next start clears it
    set_lens(10, 10, 0, 10, 10);
    step(1, 0);
    repeat (90) step(0, 0);
    rand_lens();
    step(1, 0);
    repeat (120) step(0, 0);

    // Synchronous reset in the RUN phase of layer 2
    set_lens(4, 5, 12, 4, 4);
    step(1, 0);
    for (int i = 0; i < 200 && cyc != ek[2] + 3; i++) step(0, 0);
    step(0, 1);
    repeat (6) step(0, 0);

    // Start held high: back-to-back runs, one per return to IDLE
    set_lens(2, 3, 4, 2, 3);
    repeat (80) step(1, 0);
    repeat (5) step(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
